// File: rtl/countdown_disp_pkg.sv
// Shared constants, segment lookup and FSM state type for the countdown display.
package countdown_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {a,b,c,d,e,f,g} patterns for digits 0..9.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    if (nib <= 4'd9) return SEG_TABLE[nib];
    return SEG_BLANK;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq #(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic [BIN_W-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {bcd_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(BIN_W - 1)) busy_q <= 1'b0;
    end
  end

  // done_o marks the final shift cycle; bcd_o is complete from the next cycle on.
  assign done_o = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/countdown_display_scan.sv
// Binary count to double-buffered 7-segment display with digit multiplexing.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant non-zero one.
module countdown_display_scan #(
  parameter int DIGITS   = 2,
  parameter int BIN_W    = 7,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  in_ready,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n
);
  import countdown_disp_pkg::*;

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t              state_q;
  logic                in_ready_q;
  logic                done_q;
  logic                ovf_q;
  logic                ovf_pend_q;
  logic [7*DIGITS-1:0] seg_all_q;
  logic [7*DIGITS-1:0] seg_commit_d;
  logic [PRE_W-1:0]    presc_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DIGITS-1:0]   an_n_q;
  logic [6:0]          seg_n_q;

  logic                xfer;
  logic                out_of_range;
  logic                conv_busy;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [3:0]          nib;
  logic                lead_zero;

  assign xfer         = in_valid && in_ready_q && (state_q == ST_IDLE);
  assign out_of_range = 64'(in_bin) > MAX_VAL;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (xfer),
    .bin_i   (in_bin),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    seg_commit_d = {(7*DIGITS){1'b1}};
    nib          = 4'd0;
    lead_zero    = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = conv_bcd[4*d +: 4];
      seg_commit_d[7*d +: 7] = bcd_to_seg(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (nib != 4'd0) lead_zero = 1'b0;
      if (lead_zero && (d != 0)) seg_commit_d[7*d +: 7] = SEG_BLANK;
`else
      lead_zero = 1'b0;
`endif
    end
    if (ovf_pend_q) seg_commit_d = {(7*DIGITS){1'b1}};
  end

  // seg_all only changes on the commit edge, so a conversion in flight is never visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      seg_all_q  <= {(7*DIGITS){1'b1}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            ovf_pend_q <= out_of_range;
            in_ready_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (conv_done) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          seg_all_q  <= seg_commit_d;
          ovf_q      <= ovf_pend_q;
          done_q     <= 1'b1;
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_n_q  <= {DIGITS{1'b1}};
      seg_n_q <= SEG_BLANK;
    end else begin
      if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        if (idx_q == IDX_W'(DIGITS - 1)) idx_q <= '0;
        else idx_q <= idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      an_n_q  <= ~(DIGITS'(1) << idx_q);
      seg_n_q <= seg_all_q[7*idx_q +: 7];
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign seg_all  = seg_all_q;
  assign seg_n    = seg_n_q;
  assign an_n     = an_n_q;

endmodule

// File: tb/tb_countdown_display_scan.sv
// Directed bench for countdown_display_scan (DIGITS=2, BIN_W=7, SCAN_DIV=4).
module tb_countdown_display_scan;

  localparam int DIGITS   = 2;
  localparam int BIN_W    = 7;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] BL = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic [BIN_W-1:0]    in_bin = '0;
  logic                in_ready;
  logic                done;
  logic                ovf;
  logic [7*DIGITS-1:0] seg_all;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_display_scan #(
    .DIGITS   (DIGITS),
    .BIN_W    (BIN_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bin   (in_bin),
    .in_ready (in_ready),
    .done     (done),
    .ovf      (ovf),
    .seg_all  (seg_all),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transfer v; with hold=1 in_valid stays high (in_bin=3) until done is seen.
  task automatic send(input logic [BIN_W-1:0] v, input bit hold, output int lat, output int low);
    @(negedge clk);
    check_val("ready_before_xfer", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_bin   = v;
    @(posedge clk); #1;
    if (hold) in_bin = 7'd3;
    else in_valid = 1'b0;
    low = in_ready ? 0 : 1;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready) low++;
    end
    in_valid = 1'b0;
    $display("xfer bin=%0d hold=%0d lat=%0d seg_all=%h ovf=%b", v, hold, lat, seg_all, ovf);
  endtask

  task automatic send_check(input logic [BIN_W-1:0] v, input logic [13:0] exp_seg, input logic exp_ovf);
    int lat, low;
    send(v, 1'b0, lat, low);
    check_val($sformatf("latency_%0d", v), 32'(lat), 32'd8);
    check_val($sformatf("seg_all_%0d", v), 32'(seg_all), 32'(exp_seg));
    check_val($sformatf("ovf_%0d", v), 32'(ovf), 32'(exp_ovf));
    @(posedge clk); #1;
    check_val($sformatf("done_pulse_%0d", v), 32'(done), 32'd0);
  endtask

  initial begin
    int lat, low, run, changes, dones;
    logic [DIGITS-1:0] prev;
    bit first;

    #1 rst = 1'b1;
    #2;
    check_val("rst_seg_all", 32'(seg_all), 32'h3FFF);
    check_val("rst_an_n", 32'(an_n), 32'b11);
    check_val("rst_seg_n", 32'(seg_n), 32'h7F);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    send_check(7'd45,  {S4, S5}, 1'b0);
    send_check(7'd100, {BL, BL}, 1'b1);
    send_check(7'd9,   {LZ, S9}, 1'b0);
    send_check(7'd99,  {S9, S9}, 1'b0);
    send_check(7'd127, {BL, BL}, 1'b1);
    send_check(7'd0,   {LZ, S0}, 1'b0);

    // in_valid held through conversion must not queue or replace the first value
    send(7'd45, 1'b1, lat, low);
    check_val("hold_latency", 32'(lat), 32'd8);
    check_val("hold_ready_low", 32'(low), 32'd8);
    check_val("hold_seg_all", 32'(seg_all), 32'({S4, S5}));
    @(posedge clk); #1;
    check_val("hold_no_requeue", 32'(in_ready), 32'd1);

    send_check(7'd37, {S3, S7}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    prev = an_n; run = 0; changes = 0; first = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      check_val("scan_an_valid", 32'((an_n == 2'b10) || (an_n == 2'b01)), 32'd1);
      check_val("scan_seg_n", 32'(seg_n), 32'((an_n == 2'b10) ? S7 : S3));
      if (an_n != prev) begin
        if (!first) check_val("scan_run", 32'(run), 32'(SCAN_DIV));
        first = 1'b0;
        changes++;
        run = 1;
        prev = an_n;
      end else begin
        run++;
      end
    end
    check_val("scan_toggles", 32'(changes >= 5), 32'd1);
    $display("scan an_n changes=%0d", changes);

    // Reset during the third SHIFT cycle
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 7'd55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_seg_all", 32'(seg_all), 32'h3FFF);
    check_val("mid_rst_an_n", 32'(an_n), 32'b11);
    check_val("mid_rst_seg_n", 32'(seg_n), 32'h7F);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk) rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_val("mid_rst_no_done", 32'(dones), 32'd0);
    check_val("mid_rst_seg_hold", 32'(seg_all), 32'h3FFF);
    $display("reset mid-conversion dones=%0d", dones);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
